// File: rtl/dst_port_filter.sv
// -----------------------------------------------------------------------------
// dst_port_filter
//
// Sits right after the port-swap stage. Looks at the IO-queue module header of
// each packet and throws away, in full, every packet whose one-hot destination
// field is empty or names a port outside VALID_PORT_MASK. Everything else is
// forwarded untouched. Forwarded and dropped packets are counted.
//
// Ports:
//   clk           single clock
//   reset         synchronous reset, active low
//   in_data/ctrl  word from upstream, written into the input FIFO on in_wr
//   in_wr         upstream word valid
//   in_rdy        upstream may write (FIFO below 7 entries)
//   out_data/ctrl registered word to the output queues
//   out_wr        registered word valid
//   out_rdy       downstream can take a word this cycle
//   fwd_pkt_cnt   packets forwarded (wrapping 32-bit)
//   drop_pkt_cnt  packets dropped   (wrapping 32-bit)
// -----------------------------------------------------------------------------
module dst_port_filter #(
  parameter int                  DATA_WIDTH      = 64,
  parameter int                  CTRL_WIDTH      = DATA_WIDTH/8,
  parameter logic [CTRL_WIDTH-1:0] IOQ_HDR_CTRL  = 8'hFF,
  parameter int                  DST_PORT_POS    = 48,
  parameter logic [15:0]         VALID_PORT_MASK = 16'h0055
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic [31:0]           fwd_pkt_cnt,
  output logic [31:0]           drop_pkt_cnt
);

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int FW    = CTRL_WIDTH + DATA_WIDTH;

  // ---------------------------------------------------------------------------
  // Input FIFO: fall-through, the head entry is visible combinationally as
  // soon as the count is nonzero.
  // ---------------------------------------------------------------------------
  logic [FW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic                  w_pop;
  logic                  w_empty;
  logic                  w_nearly_full;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [CTRL_WIDTH-1:0] w_head_ctrl;

  assign w_empty       = (r_count == '0);
  // One slot of slack so the upstream can still land a word that was already
  // in flight when in_rdy dropped.
  assign w_nearly_full = (r_count >= (AW+1)'(DEPTH-1));
  assign in_rdy        = !w_nearly_full;

  assign {w_head_ctrl, w_head_data} = r_mem[r_rptr];

  // Storage has no reset; validity is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (reset && in_wr)
      r_mem[r_wptr] <= {in_ctrl, in_data};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (in_wr) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AW+1)'(in_wr) - (AW+1)'(w_pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Header decode on the FIFO head
  // ---------------------------------------------------------------------------
  logic [15:0] w_dst;
  logic        w_is_hdr;
  logic        w_is_eop;
  logic        w_fwd_ok;

  assign w_dst    = w_head_data[DST_PORT_POS +: 16];
  assign w_is_hdr = (w_head_ctrl == IOQ_HDR_CTRL);
  assign w_is_eop = (w_head_ctrl != '0);
  assign w_fwd_ok = (w_dst != 16'h0) && ((w_dst & ~VALID_PORT_MASK) == 16'h0);

  // ---------------------------------------------------------------------------
  // Packet FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_FWD  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_HDR;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_HDR: begin
        if (!w_empty) begin
          if (w_is_hdr) begin
            if (!w_fwd_ok)    w_next = S_DROP;
            else if (out_rdy) w_next = S_FWD;
          end else if (!w_is_eop) begin
            // Headless multi-word fragment: discard through its EOP.
            w_next = S_DROP;
          end
        end
      end
      S_FWD: begin
        if (!w_empty && out_rdy && w_is_eop) w_next = S_HDR;
      end
      S_DROP: begin
        if (!w_empty && w_is_eop) w_next = S_HDR;
      end
      default: w_next = S_HDR;
    endcase
  end

  logic w_emit;
  logic w_inc_fwd;
  logic w_inc_drop;

  always_comb begin
    w_pop      = 1'b0;
    w_emit     = 1'b0;
    w_inc_fwd  = 1'b0;
    w_inc_drop = 1'b0;
    unique case (r_state)
      S_HDR: begin
        if (!w_empty) begin
          if (w_is_hdr && w_fwd_ok) begin
            // Forwarded header waits for downstream space.
            if (out_rdy) begin
              w_pop     = 1'b1;
              w_emit    = 1'b1;
              w_inc_fwd = 1'b1;
            end
          end else begin
            // Bad header or stray word: consumed without looking at out_rdy.
            w_pop      = 1'b1;
            w_inc_drop = 1'b1;
          end
        end
      end
      S_FWD: begin
        if (!w_empty && out_rdy) begin
          w_pop  = 1'b1;
          w_emit = 1'b1;
        end
      end
      S_DROP: begin
        if (!w_empty) w_pop = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register and counters
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [CTRL_WIDTH-1:0] r_out_ctrl;
  logic                  r_out_wr;
  logic [31:0]           r_fwd_cnt;
  logic [31:0]           r_drop_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out_wr   <= 1'b0;
      r_out_data <= '0;
      r_out_ctrl <= '0;
    end else begin
      r_out_wr <= w_emit;
      if (w_emit) begin
        r_out_data <= w_head_data;
        r_out_ctrl <= w_head_ctrl;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fwd_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_inc_fwd)  r_fwd_cnt  <= r_fwd_cnt + 32'd1;
      if (w_inc_drop) r_drop_cnt <= r_drop_cnt + 32'd1;
    end
  end

  assign out_wr       = r_out_wr;
  assign out_data     = r_out_data;
  assign out_ctrl     = r_out_ctrl;
  assign fwd_pkt_cnt  = r_fwd_cnt;
  assign drop_pkt_cnt = r_drop_cnt;

endmodule

// File: doc/dst_port_filter.md
# dst_port_filter

Datapath stage placed directly downstream of the port-swap stage in the user data path. It inspects the IO-queue module header of each packet. Packets whose destination-port field is empty or names a port outside an allowed mask are discarded in full. All other packets are forwarded unchanged to the output queues. Forwarded and dropped packets are counted for register readout.

## Interface
Parameters:
- DATA_WIDTH, 64, data word width
- CTRL_WIDTH, DATA_WIDTH/8, control word width
- IOQ_HDR_CTRL, 8'hFF, ctrl value marking the IO-queue module header
- DST_PORT_POS, 48, LSB of the 16-bit one-hot destination-port field in the header word
- VALID_PORT_MASK, 16'h0055, legal destination bits (MAC ports 0-3)

Ports:
- clk  in  1  single clock
- reset  in  1  **synchronous, active-low** reset (asserted when 0)
- in_data  in  DATA_WIDTH  word from upstream
- in_ctrl  in  CTRL_WIDTH  ctrl from upstream
- in_wr  in  1  word valid
- in_rdy  out  1  high = upstream may write
- out_data  out  DATA_WIDTH  registered word to downstream
- out_ctrl  out  CTRL_WIDTH  registered ctrl
- out_wr  out  1  registered word valid
- out_rdy  in  1  downstream can accept a word this cycle
- fwd_pkt_cnt  out  32  packets forwarded (wraps)
- drop_pkt_cnt  out  32  packets dropped (wraps)

## Operation
- Input buffer: fall-through FIFO, 8 entries, width CTRL_WIDTH+DATA_WIDTH.
  - Written on in_wr.
  - in_rdy = !nearly_full (nearly_full at ≥7 entries).
  - A write while full is an upstream protocol violation and is not defended.
- Packet framing:
  - First word of every packet carries ctrl == IOQ_HDR_CTRL.
  - Body words have ctrl == 0.
  - The last word has nonzero ctrl (byte mask).
- Destination field: dst = header[DST_PORT_POS+15:DST_PORT_POS].
  - Forward iff dst != 0 and (dst & ~VALID_PORT_MASK) == 0.
- State machine, states HDR, FWD, DROP:
  - HDR, FIFO non-empty, head ctrl == IOQ_HDR_CTRL, forward decision:
    - Requires out_rdy.
    - Pop, emit the word, fwd_pkt_cnt += 1, go FWD.
  - HDR, FIFO non-empty, head ctrl == IOQ_HDR_CTRL, drop decision:
    - Pop regardless of out_rdy, no output.
    - drop_pkt_cnt += 1, go DROP.
  - HDR, FIFO non-empty, head ctrl != IOQ_HDR_CTRL (stray word):
    - Pop, no output, drop_pkt_cnt += 1.
    - If ctrl == 0, go DROP; otherwise stay HDR (single-word stray).
  - FWD: each cycle with out_rdy && !empty, pop and emit. Emitting a word with ctrl != 0 returns to HDR.
  - DROP: each cycle with !empty, pop without emitting. Popping a word with ctrl != 0 returns to HDR.
- Data and ctrl pass through bit-exact; the header word is not modified.
- Counters are 32-bit and wrap from 0xFFFFFFFF to 0. Each increments exactly once per packet, in the cycle the header is popped.

## Timing
- Reset values (reset == 0 at a clk edge):
  - out_wr = 0, out_data = 0, out_ctrl = 0.
  - fwd_pkt_cnt = 0, drop_pkt_cnt = 0.
  - State = HDR, FIFO emptied.
  - in_rdy = 1 from the first cycle after reset deasserts.
- Reset mid-packet discards the partial packet in the FIFO. The next accepted word must be a header.
- Latency:
  - A word written to an empty FIFO at edge N is poppable in cycle N+1.
  - out_wr rises at edge N+2 (one output register).
- out_rdy is sampled combinationally in the pop cycle. The registered word appears on the next edge. Downstream must absorb one in-flight word after dropping out_rdy.
- Throughput: one word per cycle in FWD and DROP. A dropped packet costs one cycle per word and never stalls on out_rdy.
- Simultaneous FIFO write and pop is allowed every cycle, including at the nearly_full boundary.
- HDR→FWD/DROP and FWD/DROP→HDR add no idle cycles. Back-to-back packets stream without gaps.

## Test plan
- Header dst=0x0004, 3 body words, last ctrl=0x80, out_rdy=1 -> 5 words out bit-exact, out_wr first at +2 cycles after first in_wr, fwd_pkt_cnt=1.
- Header dst=0x0000, then header dst=0x0002 (bit outside mask 0x0055), each 4 words -> no out_wr at all, drop_pkt_cnt=2, in_rdy never deasserts.
- Forwarded packet then dropped packet then forwarded packet back-to-back, out_rdy toggling 1/0 every cycle -> only the two forwarded packets appear, in order and intact; fwd=2, drop=1.
- out_rdy=0 for 20 cycles while 10 words are offered -> in_rdy falls after the 7th word buffered, no word lost; release out_rdy -> all words emitted in order.
- Stray body word (ctrl=0) in HDR followed by the rest of a headerless packet, then a valid packet -> stray packet discarded through its EOP, drop_pkt_cnt=1, valid packet forwarded.
- Assert reset (0) mid-way through a forwarded packet -> outputs and counters 0 next cycle; after release, a new packet forwards correctly. Also preload fwd_pkt_cnt to 0xFFFFFFFF (force) and forward one packet -> wraps to 0.
